multicycle_ctrl_fsm: RTL and testbench

//  Main sequencing FSM of the multi-cycle RV32I core. Drives IRwrite into the instruction/oldPC latch, plus PC, memory, register-file and ALU mux controls.

---
 rtl/riscv_mc_pkg.sv | 59 +++++
 rtl/multicycle_out_dec.sv | 85 ++++++++
 rtl/multicycle_ctrl_fsm.sv | 95 +++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I core: FSM states, opcodes, datapath mux selects.
// Build option: ILLEGAL_TRAP_EN adds the TRAP state for unknown opcodes.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd11
`endif
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       mem_req;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_out_dec.sv
// Combinational state -> control-word decode for the multi-cycle core sequencer.
// Build option: ILLEGAL_TRAP_EN enables the TRAP state decode.
module multicycle_out_dec
  import riscv_mc_pkg::*;
(
  input  state_e state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.mem_req    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEM;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencing FSM of the multi-cycle RV32I core: state register, next-state logic, reset gating.
// Build option: ILLEGAL_TRAP_EN sends unknown opcodes to a sticky TRAP state.
module multicycle_ctrl_fsm
  import riscv_mc_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               IRwrite,
  output logic               PCwrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               mem_req,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] fsm_state
);

  state_e     state_q, state_d;
  ctrl_t      ctrl;
  logic [6:0] opcode;
  logic       unused_instr_hi;

  assign opcode          = instr[6:0];
  assign unused_instr_hi = ^instr[31:7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  multicycle_out_dec u_out_dec (
    .state     (state_q),
    .zero      (Zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Strobes are gated by reset directly so they drop in the same cycle reset falls.
  assign IRwrite       = reset & ctrl.ir_write;
  assign PCwrite       = reset & ctrl.pc_write;
  assign MemWrite      = reset & ctrl.mem_write;
  assign mem_req       = reset & ctrl.mem_req;
  assign RegWrite      = reset & ctrl.reg_write;
  assign illegal_instr = reset & ctrl.illegal;
  assign AdrSrc        = ctrl.adr_src;
  assign ResultSrc     = ctrl.result_src;
  assign ALUSrcA       = ctrl.alu_src_a;
  assign ALUSrcB       = ctrl.alu_src_b;
  assign ALUOp         = ctrl.alu_op;
  assign fsm_state     = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm; honours ILLEGAL_TRAP_EN for the unknown-opcode case.
module tb_multicycle_ctrl_fsm;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECUTER = 6, S_EXECUTEI = 7, S_ALUWB = 8,
                 S_BEQ = 9, S_JAL = 10, S_TRAP = 11;

  // strobe order: {IRwrite, PCwrite, MemWrite, mem_req, RegWrite, illegal_instr}
  localparam logic [5:0] ST_NONE  = 6'b000000;
  localparam logic [5:0] ST_FETCH = 6'b110100;
  localparam logic [5:0] ST_REQ   = 6'b000100;
  localparam logic [5:0] ST_WB    = 6'b000010;
  localparam logic [5:0] ST_MEMW  = 6'b001100;
  localparam logic [5:0] ST_PCW   = 6'b010000;
  localparam logic [5:0] ST_ILL   = 6'b000001;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h00000013;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        IRwrite, PCwrite, AdrSrc, MemWrite, mem_req, RegWrite, illegal_instr;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0]  fsm_state;

  multicycle_ctrl_fsm #(.STATE_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .Zero          (Zero),
    .mem_ready     (mem_ready),
    .IRwrite       (IRwrite),
    .PCwrite       (PCwrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .mem_req       (mem_req),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .illegal_instr (illegal_instr),
    .fsm_state     (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         st;
    logic [5:0] strb;
    logic [8:0] mux;
    logic [8:0] mask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // mux order: {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}; mask covers fields defined for that state
  task automatic exp_mux(input int st, output logic [8:0] v, output logic [8:0] m);
    case (st)
      S_FETCH:    begin v = 9'b0_10_00_10_00; m = 9'b1_11_11_11_11; end
      S_DECODE:   begin v = 9'b0_00_01_01_00; m = 9'b0_00_11_11_11; end
      S_MEMADR:   begin v = 9'b0_00_10_01_00; m = 9'b0_00_11_11_11; end
      S_MEMREAD:  begin v = 9'b1_00_00_00_00; m = 9'b1_11_00_00_00; end
      S_MEMWB:    begin v = 9'b0_01_00_00_00; m = 9'b0_11_00_00_00; end
      S_MEMWRITE: begin v = 9'b1_00_00_00_00; m = 9'b1_00_00_00_00; end
      S_EXECUTER: begin v = 9'b0_00_10_00_10; m = 9'b0_00_11_11_11; end
      S_EXECUTEI: begin v = 9'b0_00_10_01_10; m = 9'b0_00_11_11_11; end
      S_ALUWB:    begin v = 9'b0_00_00_00_00; m = 9'b0_11_00_00_00; end
      S_BEQ:      begin v = 9'b0_00_10_00_01; m = 9'b0_11_11_11_11; end
      S_JAL:      begin v = 9'b0_00_01_10_00; m = 9'b0_11_11_11_11; end
      default:    begin v = 9'b0;             m = 9'b0;             end
    endcase
  endtask

  // Inputs change just after the edge; the expectation covers the cycle that follows.
  task automatic step(input string nm, input logic rst, input logic [31:0] ins,
                      input logic z, input logic rdy, input int st, input logic [5:0] strb);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    instr     = ins;
    Zero      = z;
    mem_ready = rdy;
    e.name = nm;
    e.st   = st;
    e.strb = strb;
    exp_mux(st, e.mux, e.mask);
    sb.push_back(e);
  endtask

  exp_t       mon_e;
  logic [5:0] act_strb;
  logic [8:0] act_mux;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e    = sb.pop_front();
      act_strb = {IRwrite, PCwrite, MemWrite, mem_req, RegWrite, illegal_instr};
      act_mux  = {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
      checks++;
      if (int'(fsm_state) != mon_e.st) begin
        failures++;
        $display("FAIL %s state: got %0d expected %0d", mon_e.name, fsm_state, mon_e.st);
      end
      checks++;
      if (act_strb !== mon_e.strb) begin
        failures++;
        $display("FAIL %s strobes: got %b expected %b", mon_e.name, act_strb, mon_e.strb);
      end
      checks++;
      if ((act_mux & mon_e.mask) !== (mon_e.mux & mon_e.mask)) begin
        failures++;
        $display("FAIL %s muxes: got %b expected %b (mask %b)",
                 mon_e.name, act_mux, mon_e.mux, mon_e.mask);
      end
    end
  end

  initial begin
    step("reset0",     1'b0, I_ADD, 1'b0, 1'b1, S_FETCH,    ST_NONE);
    step("reset1",     1'b0, I_ADD, 1'b0, 1'b1, S_FETCH,    ST_NONE);
    step("add_fetch",  1'b1, I_ADD, 1'b0, 1'b1, S_FETCH,    ST_FETCH);
    step("add_dec",    1'b1, I_ADD, 1'b0, 1'b1, S_DECODE,   ST_NONE);
    step("add_exe",    1'b1, I_ADD, 1'b0, 1'b1, S_EXECUTER, ST_NONE);
    step("add_wb",     1'b1, I_ADD, 1'b0, 1'b1, S_ALUWB,    ST_WB);

    step("lw_fstall",  1'b1, I_LW,  1'b0, 1'b0, S_FETCH,    ST_REQ);
    step("lw_fetch",   1'b1, I_LW,  1'b0, 1'b1, S_FETCH,    ST_FETCH);
    step("lw_dec",     1'b1, I_LW,  1'b0, 1'b1, S_DECODE,   ST_NONE);
    step("lw_adr",     1'b1, I_LW,  1'b0, 1'b1, S_MEMADR,   ST_NONE);
    step("lw_rd0",     1'b1, I_LW,  1'b0, 1'b0, S_MEMREAD,  ST_REQ);
    step("lw_rd1",     1'b1, I_LW,  1'b0, 1'b0, S_MEMREAD,  ST_REQ);
    step("lw_rd2",     1'b1, I_LW,  1'b0, 1'b1, S_MEMREAD,  ST_REQ);
    step("lw_wb",      1'b1, I_LW,  1'b0, 1'b1, S_MEMWB,    ST_WB);

    step("beqt_fetch", 1'b1, I_BEQ, 1'b1, 1'b1, S_FETCH,    ST_FETCH);
    step("beqt_dec",   1'b1, I_BEQ, 1'b1, 1'b1, S_DECODE,   ST_NONE);
    step("beqt_exe",   1'b1, I_BEQ, 1'b1, 1'b1, S_BEQ,      ST_PCW);
    step("beqn_fetch", 1'b1, I_BEQ, 1'b0, 1'b1, S_FETCH,    ST_FETCH);
    step("beqn_dec",   1'b1, I_BEQ, 1'b0, 1'b1, S_DECODE,   ST_NONE);
    step("beqn_exe",   1'b1, I_BEQ, 1'b0, 1'b1, S_BEQ,      ST_NONE);

    step("jal_fetch",  1'b1, I_JAL, 1'b0, 1'b1, S_FETCH,    ST_FETCH);
    step("jal_dec",    1'b1, I_JAL, 1'b0, 1'b1, S_DECODE,   ST_NONE);
    step("jal_exe",    1'b1, I_JAL, 1'b0, 1'b1, S_JAL,      ST_PCW);
    step("jal_wb",     1'b1, I_JAL, 1'b0, 1'b1, S_ALUWB,    ST_WB);

    step("addi_fetch", 1'b1, I_ADDI, 1'b0, 1'b1, S_FETCH,    ST_FETCH);
    step("addi_dec",   1'b1, I_ADDI, 1'b0, 1'b1, S_DECODE,   ST_NONE);
    step("addi_exe",   1'b1, I_ADDI, 1'b0, 1'b1, S_EXECUTEI, ST_NONE);
    step("addi_wb",    1'b1, I_ADDI, 1'b0, 1'b1, S_ALUWB,    ST_WB);

    step("sw_fetch",   1'b1, I_SW, 1'b0, 1'b1, S_FETCH,    ST_FETCH);
    step("sw_dec",     1'b1, I_SW, 1'b0, 1'b1, S_DECODE,   ST_NONE);
    step("sw_adr",     1'b1, I_SW, 1'b0, 1'b1, S_MEMADR,   ST_NONE);
    step("sw_wr0",     1'b1, I_SW, 1'b0, 1'b0, S_MEMWRITE, ST_MEMW);
    step("sw_wr1",     1'b1, I_SW, 1'b0, 1'b1, S_MEMWRITE, ST_MEMW);
    step("sw2_fetch",  1'b1, I_SW, 1'b0, 1'b1, S_FETCH,    ST_FETCH);
    step("sw2_dec",    1'b1, I_SW, 1'b0, 1'b1, S_DECODE,   ST_NONE);
    step("sw2_adr",    1'b1, I_SW, 1'b0, 1'b1, S_MEMADR,   ST_NONE);
    step("sw2_wr",     1'b1, I_SW, 1'b0, 1'b0, S_MEMWRITE, ST_MEMW);
    step("sw2_abort",  1'b0, I_SW, 1'b0, 1'b0, S_FETCH,    ST_NONE);
    step("sw2_hold",   1'b0, I_SW, 1'b0, 1'b1, S_FETCH,    ST_NONE);

    step("ill_fetch",  1'b1, I_ILL, 1'b0, 1'b1, S_FETCH,    ST_FETCH);
    step("ill_dec",    1'b1, I_ILL, 1'b0, 1'b1, S_DECODE,   ST_NONE);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      step($sformatf("trap%0d", i), 1'b1, I_ILL, 1'b1, 1'b1, S_TRAP, ST_ILL);
    step("trap_rst",   1'b0, I_ADD, 1'b0, 1'b1, S_FETCH,    ST_NONE);
    step("trap_rel",   1'b1, I_ADD, 1'b0, 1'b1, S_FETCH,    ST_FETCH);
`else
    step("ill_nop",    1'b1, I_ADD, 1'b0, 1'b1, S_FETCH,    ST_FETCH);
`endif
    step("post_dec",   1'b1, I_ADD, 1'b0, 1'b1, S_DECODE,   ST_NONE);
    step("post_exe",   1'b1, I_ADD, 1'b0, 1'b1, S_EXECUTER, ST_NONE);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
